icc_branch_unit: RTL and testbench

//  Consumer side of the ALU flag interface: latches N/Z/C/V into the integer condition-code register (icc) on S-bit ops.

---
 rtl/icc_branch_unit_pkg.sv | 44 ++++
 rtl/icc_cond_eval.sv | 29 ++
 rtl/icc_branch_unit.sv | 118 +++++++++++
 tb/tb_icc_branch_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icc_branch_unit_pkg.sv
// Shared types for the integer condition-code / Bicc branch unit: flag struct,
// SPARC condition encodings, branch FSM states and the delay-slot squash rule.
package icc_pkg;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } icc_t;

    localparam int OPC_S_BIT = 4;
    localparam int OPC_X_BIT = 3;

    localparam logic [3:0] COND_BN   = 4'b0000;
    localparam logic [3:0] COND_BE   = 4'b0001;
    localparam logic [3:0] COND_BLE  = 4'b0010;
    localparam logic [3:0] COND_BL   = 4'b0011;
    localparam logic [3:0] COND_BLEU = 4'b0100;
    localparam logic [3:0] COND_BCS  = 4'b0101;
    localparam logic [3:0] COND_BNEG = 4'b0110;
    localparam logic [3:0] COND_BVS  = 4'b0111;
    localparam logic [3:0] COND_BA   = 4'b1000;
    localparam logic [3:0] COND_BNE  = 4'b1001;
    localparam logic [3:0] COND_BG   = 4'b1010;
    localparam logic [3:0] COND_BGE  = 4'b1011;
    localparam logic [3:0] COND_BGU  = 4'b1100;
    localparam logic [3:0] COND_BCC  = 4'b1101;
    localparam logic [3:0] COND_BPOS = 4'b1110;
    localparam logic [3:0] COND_BVC  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        RESOLVE,
        SLOT
    } state_e;

    // Annulled branches kill their slot when not taken; BA,a kills it even though taken.
    function automatic logic slot_squash(input logic annul, input logic taken,
                                         input logic [3:0] cond);
        return annul && (!taken || (cond == COND_BA));
    endfunction

endpackage

// File: rtl/icc_cond_eval.sv
// Combinational SPARC Bicc condition evaluator; the upper cond bit inverts the
// base test, which is how codes 1001-1111 complement 0001-0111 and BA complements BN.
module icc_cond_eval
    import icc_pkg::*;
(
    input  icc_t       icc_i,
    input  logic [3:0] cond_i,
    output logic       taken_o
);

    logic base;

    always_comb begin
        base = 1'b0;
        case (cond_i[2:0])
            3'b000: base = 1'b0;
            3'b001: base = icc_i.z;
            3'b010: base = icc_i.z | (icc_i.n ^ icc_i.v);
            3'b011: base = icc_i.n ^ icc_i.v;
            3'b100: base = icc_i.c | icc_i.z;
            3'b101: base = icc_i.c;
            3'b110: base = icc_i.n;
            3'b111: base = icc_i.v;
            default: base = 1'b0;
        endcase
        taken_o = base ^ cond_i[3];
    end

endmodule

// File: rtl/icc_branch_unit.sv
// Integer condition-code register plus Bicc resolve / delay-slot annul FSM.
// Define ICC_BYPASS_EN to forward same-cycle ALU flags into the branch snapshot.
module icc_branch_unit
    import icc_pkg::*;
#(
    parameter logic [3:0] ICC_RESET = 4'b0000,
    parameter int         COND_W    = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              alu_valid_i,
    input  logic [5:0]        alu_opcode_i,
    input  logic              alu_n_i,
    input  logic              alu_z_i,
    input  logic              alu_c_i,
    input  logic              alu_v_i,
    output logic              alu_carry_o,
    output logic [3:0]        icc_o,
    input  logic              br_valid_i,
    input  logic [COND_W-1:0] br_cond_i,
    input  logic              br_annul_i,
    output logic              br_ready_o,
    output logic              br_resp_valid_o,
    output logic              br_taken_o,
    input  logic              slot_valid_i,
    output logic              slot_annul_o
);

    state_e            state_q, state_d;
    icc_t              icc_q, icc_d;
    icc_t              snap_icc_q, snap_icc_d;
    logic [COND_W-1:0] snap_cond_q, snap_cond_d;
    logic              snap_annul_q, snap_annul_d;

    icc_t alu_flags;
    logic alu_sets_cc;
    logic snap_taken;
    logic squash;
    logic slot_killed;
    logic unused_opcode_bits;

    assign alu_flags   = '{n: alu_n_i, z: alu_z_i, c: alu_c_i, v: alu_v_i};
    assign alu_sets_cc = alu_valid_i && alu_opcode_i[OPC_S_BIT];

    // The use-carry bit only matters inside the ALU; carry-in is always icc.C.
    assign unused_opcode_bits = ^{alu_opcode_i[5], alu_opcode_i[OPC_X_BIT],
                                  alu_opcode_i[2:0]};

    icc_cond_eval u_cond_eval (
        .icc_i   (snap_icc_q),
        .cond_i  (snap_cond_q),
        .taken_o (snap_taken)
    );

    assign squash      = slot_squash(snap_annul_q, snap_taken, snap_cond_q);
    assign slot_killed = (state_q == SLOT) && slot_valid_i && squash;

    always_comb begin
        state_d      = state_q;
        icc_d        = icc_q;
        snap_icc_d   = snap_icc_q;
        snap_cond_d  = snap_cond_q;
        snap_annul_d = snap_annul_q;

        case (state_q)
            IDLE: begin
                if (br_valid_i) begin
                    state_d      = RESOLVE;
                    snap_cond_d  = br_cond_i;
                    snap_annul_d = br_annul_i;
`ifdef ICC_BYPASS_EN
                    snap_icc_d   = alu_sets_cc ? alu_flags : icc_q;
`else
                    snap_icc_d   = icc_q;
`endif
                end
            end
            RESOLVE: state_d = SLOT;
            SLOT: begin
                if (slot_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A squashed delay-slot instruction must not leave its flags behind.
        if (alu_sets_cc && !slot_killed) begin
            icc_d = alu_flags;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            icc_q        <= icc_t'(ICC_RESET);
            snap_icc_q   <= icc_t'(ICC_RESET);
            snap_cond_q  <= COND_BN;
            snap_annul_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            icc_q        <= icc_d;
            snap_icc_q   <= snap_icc_d;
            snap_cond_q  <= snap_cond_d;
            snap_annul_q <= snap_annul_d;
        end
    end

    // Responses are gated by rst so a reset cycle never emits a stale outcome.
    assign br_ready_o      = (state_q == IDLE);
    assign br_resp_valid_o = (state_q == RESOLVE) && !rst_i;
    assign br_taken_o      = (state_q == RESOLVE) && !rst_i && snap_taken;
    assign slot_annul_o    = (state_q == SLOT) && !rst_i && squash;

    assign alu_carry_o = icc_q.c;
    assign icc_o       = icc_q;

endmodule

// File: tb/tb_icc_branch_unit.sv
// Self-checking bench for icc_branch_unit: condition table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_icc_branch_unit;

    logic       clk;
    logic       rst;
    logic       aluValid;
    logic [5:0] aluOpcode;
    logic       aluN, aluZ, aluC, aluV;
    logic       aluCarry;
    logic [3:0] iccOut;
    logic       brValid;
    logic [3:0] brCond;
    logic       brAnnul;
    logic       brReady;
    logic       brRespValid;
    logic       brTaken;
    logic       slotValid;
    logic       slotAnnul;

    int checkCount = 0;
    int passCount  = 0;

    icc_branch_unit dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .alu_valid_i     (aluValid),
        .alu_opcode_i    (aluOpcode),
        .alu_n_i         (aluN),
        .alu_z_i         (aluZ),
        .alu_c_i         (aluC),
        .alu_v_i         (aluV),
        .alu_carry_o     (aluCarry),
        .icc_o           (iccOut),
        .br_valid_i      (brValid),
        .br_cond_i       (brCond),
        .br_annul_i      (brAnnul),
        .br_ready_o      (brReady),
        .br_resp_valid_o (brRespValid),
        .br_taken_o      (brTaken),
        .slot_valid_i    (slotValid),
        .slot_annul_o    (slotAnnul)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cond;
        logic [3:0] icc;
        logic       annul;
        logic       expTaken;
        logic       expSquash;
    } branchVec_t;

    branchVec_t vecs[18];

    // Behavioural model: flags, pending branch and which phase it is in.
    logic [3:0] mIcc;
    bit         mWaitResp;
    bit         mInSlot;
    logic [3:0] mCond;
    bit         mAnnul;
    logic [3:0] mSnapIcc;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic av, input logic [5:0] op,
                                 input logic [3:0] flags, input logic bv,
                                 input logic [3:0] cond, input logic ba, input logic sv);
        rst       = r;
        aluValid  = av;
        aluOpcode = op;
        {aluN, aluZ, aluC, aluV} = flags;
        brValid   = bv;
        brCond    = cond;
        brAnnul   = ba;
        slotValid = sv;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'b0, 6'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    endtask

    task automatic setIcc(input logic [3:0] flags);
        applyStimulus(1'b0, 1'b1, 6'b010000, flags, 1'b0, 4'b0, 1'b0, 1'b0);
        tick();
        idleInputs();
    endtask

    // Spelled out per SPARC mnemonic rather than via a complement trick.
    function automatic bit refTaken(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'd0:  return 1'b0;
            4'd1:  return z;
            4'd2:  return z | (n ^ v);
            4'd3:  return n ^ v;
            4'd4:  return c | z;
            4'd5:  return c;
            4'd6:  return n;
            4'd7:  return v;
            4'd8:  return 1'b1;
            4'd9:  return !z;
            4'd10: return !(z | (n ^ v));
            4'd11: return n == v;
            4'd12: return !c && !z;
            4'd13: return !c;
            4'd14: return !n;
            default: return !v;
        endcase
    endfunction

    initial begin
        bit         r, av, bv, ba, sv, expT, expSq, sqNow;
        logic [5:0] op;
        logic [3:0] flags, cond;
        logic       bypassExp;

        vecs[0]  = '{4'b0001, 4'b0100, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{4'b1000, 4'b0000, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{4'b0010, 4'b1000, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{4'b0011, 4'b1001, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'b0100, 4'b0010, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{4'b1100, 4'b0000, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{4'b1010, 4'b0100, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{4'b1011, 4'b1001, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{4'b1101, 4'b0010, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{4'b1110, 4'b1000, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{4'b0111, 4'b0001, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{4'b0110, 4'b1000, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{4'b0101, 4'b0000, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{4'b1001, 4'b0000, 1'b0, 1'b1, 1'b0};

        // Reset values
        applyStimulus(1'b1, 1'b0, 6'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        tick();
        tick();
        idleInputs();
        checkOutput("reset icc", iccOut, 4'b0000);
        checkOutput("reset br_ready", brReady, 1'b1);
        checkOutput("reset resp_valid", brRespValid, 1'b0);
        checkOutput("reset taken", brTaken, 1'b0);
        checkOutput("reset slot_annul", slotAnnul, 1'b0);

        // S-op updates icc, non-S op leaves it alone
        applyStimulus(1'b0, 1'b1, 6'b010001, 4'b0100, 1'b0, 4'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 6'b000001, 4'b0000, 1'b0, 4'b0, 1'b0, 1'b0);
        checkOutput("S op icc", iccOut, 4'b0100);
        tick();
        idleInputs();
        checkOutput("non-S op icc hold", iccOut, 4'b0100);

        setIcc(4'b0010);
        checkOutput("carry from icc.C", aluCarry, 1'b1);
        applyStimulus(1'b0, 1'b1, 6'b011100, 4'b1000, 1'b0, 4'b0, 1'b0, 1'b0);
        tick();
        idleInputs();
        checkOutput("SUBX icc", iccOut, 4'b1000);
        checkOutput("SUBX carry", aluCarry, 1'b0);

        // Condition table through the full accept/resolve/slot sequence
        for (int i = 0; i < 18; i++) begin
            setIcc(vecs[i].icc);
            checkOutput($sformatf("vec%0d icc", i), iccOut, {28'b0, vecs[i].icc});
            applyStimulus(1'b0, 1'b0, 6'b0, 4'b0, 1'b1, vecs[i].cond, vecs[i].annul, 1'b0);
            checkOutput($sformatf("vec%0d ready", i), brReady, 1'b1);
            tick();
            idleInputs();
            checkOutput($sformatf("vec%0d resp_valid", i), brRespValid, 1'b1);
            checkOutput($sformatf("vec%0d taken", i), brTaken, vecs[i].expTaken);
            tick();
            checkOutput($sformatf("vec%0d resp drops", i), brRespValid, 1'b0);
            applyStimulus(1'b0, 1'b0, 6'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b1);
            checkOutput($sformatf("vec%0d slot_annul", i), slotAnnul, vecs[i].expSquash);
            tick();
            idleInputs();
            checkOutput($sformatf("vec%0d back idle", i), brReady, 1'b1);
        end

        // Annulled slot op must not write icc
        setIcc(4'b0000);
        applyStimulus(1'b0, 1'b0, 6'b0, 4'b0, 1'b1, 4'b0001, 1'b1, 1'b0);
        tick();
        idleInputs();
        tick();
        applyStimulus(1'b0, 1'b1, 6'b010000, 4'b1111, 1'b0, 4'b0, 1'b0, 1'b1);
        checkOutput("annulled slot squash", slotAnnul, 1'b1);
        tick();
        idleInputs();
        checkOutput("annulled slot icc", iccOut, 4'b0000);

        // DCTI couple: branch held through RESOLVE/SLOT is not accepted
        setIcc(4'b0100);
        applyStimulus(1'b0, 1'b0, 6'b0, 4'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
        tick();
        checkOutput("dcti ready resolve", brReady, 1'b0);
        tick();
        checkOutput("dcti ready slot", brReady, 1'b0);
        tick();
        checkOutput("dcti ready slot2", brReady, 1'b0);
        checkOutput("dcti no resp", brRespValid, 1'b0);
        applyStimulus(1'b0, 1'b0, 6'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        tick();
        idleInputs();
        checkOutput("dcti idle", brReady, 1'b1);
        tick();
        checkOutput("dcti no accept", brRespValid, 1'b0);

        // Reset while in SLOT
        setIcc(4'b1110);
        applyStimulus(1'b0, 1'b0, 6'b0, 4'b0, 1'b1, 4'b1000, 1'b1, 1'b0);
        tick();
        idleInputs();
        tick();
        checkOutput("pre-rst slot annul", slotAnnul, 1'b1);
        applyStimulus(1'b1, 1'b0, 6'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        checkOutput("rst drops slot_annul", slotAnnul, 1'b0);
        tick();
        idleInputs();
        checkOutput("rst slot ready", brReady, 1'b1);
        checkOutput("rst slot icc", iccOut, 4'b0000);

        // Same-cycle S-op and Bicc
`ifdef ICC_BYPASS_EN
        bypassExp = 1'b1;
`else
        bypassExp = 1'b0;
`endif
        setIcc(4'b0000);
        applyStimulus(1'b0, 1'b1, 6'b010000, 4'b0100, 1'b1, 4'b0001, 1'b0, 1'b0);
        tick();
        idleInputs();
        checkOutput("bypass resp", brRespValid, 1'b1);
        checkOutput("bypass taken", brTaken, bypassExp);
        tick();
        applyStimulus(1'b0, 1'b0, 6'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        tick();

        // Randomized run against the model
        applyStimulus(1'b1, 1'b0, 6'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        tick();
        mIcc = 4'b0000;
        mWaitResp = 1'b0;
        mInSlot = 1'b0;
        mCond = 4'b0000;
        mAnnul = 1'b0;
        mSnapIcc = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            r     = ($urandom_range(0, 49) == 0);
            av    = $urandom_range(0, 1) == 1;
            op    = 6'($urandom);
            flags = 4'($urandom);
            bv    = $urandom_range(0, 2) != 0;
            cond  = 4'($urandom);
            ba    = $urandom_range(0, 1) == 1;
            sv    = $urandom_range(0, 2) == 0;
            applyStimulus(r, av, op, flags, bv, cond, ba, sv);

            expT  = refTaken(mCond, mSnapIcc);
            expSq = mAnnul && (!expT || mCond == 4'b1000);
            checkOutput("rnd icc", iccOut, mIcc);
            checkOutput("rnd carry", aluCarry, mIcc[1]);
            checkOutput("rnd ready", brReady, !mWaitResp && !mInSlot);
            checkOutput("rnd resp", brRespValid, mWaitResp && !r);
            checkOutput("rnd taken", brTaken, mWaitResp && !r && expT);
            checkOutput("rnd slot_annul", slotAnnul, mInSlot && !r && expSq);

            if (r) begin
                mIcc = 4'b0000;
                mWaitResp = 1'b0;
                mInSlot = 1'b0;
            end else begin
                sqNow = mInSlot && sv && expSq;
                if (!mWaitResp && !mInSlot && bv) begin
                    mCond = cond;
                    mAnnul = ba;
                    mSnapIcc = mIcc;
`ifdef ICC_BYPASS_EN
                    if (av && op[4]) mSnapIcc = flags;
`endif
                    mWaitResp = 1'b1;
                end else if (mWaitResp) begin
                    mWaitResp = 1'b0;
                    mInSlot = 1'b1;
                end else if (mInSlot && sv) begin
                    mInSlot = 1'b0;
                end
                if (av && op[4] && !sqNow) mIcc = flags;
            end
            tick();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
